// File: rtl/sss_pkg.sv
// Shared constants, FSM state type and the two reference m-sequences for the
// NR SSS detector.
package sss_pkg;

    localparam int N_ID_1_MAX = 335;
    localparam int SSS_LEN    = 127;
    localparam int N_ID_MAX   = 1007;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SEARCH,
        ST_OUTPUT
    } state_t;

    // x0(i+7) = x0(i+4) ^ x0(i), seeded 1,0,0,0,0,0,0; bit i of the result is x0(i).
    function automatic logic [SSS_LEN-1:0] gen_x0();
        logic [SSS_LEN-1:0] x;
        x    = '0;
        x[0] = 1'b1;
        for (int i = 0; i < SSS_LEN - 7; i++) begin
            x[i+7] = x[i+4] ^ x[i];
        end
        return x;
    endfunction

    // x1(i+7) = x1(i+1) ^ x1(i), same seed as x0.
    function automatic logic [SSS_LEN-1:0] gen_x1();
        logic [SSS_LEN-1:0] x;
        x    = '0;
        x[0] = 1'b1;
        for (int i = 0; i < SSS_LEN - 7; i++) begin
            x[i+7] = x[i+1] ^ x[i];
        end
        return x;
    endfunction

endpackage

// File: rtl/sss_seq_gen.sv
// Combinational SSS reference bit e(n) for a given (N_id_1, N_id_2, n):
// cyclic shifts m0/m1 applied to constant x0/x1 ROMs with mod-127 index adders.
module sss_seq_gen
    import sss_pkg::*;
(
    input  logic [8:0] n_id_1,
    input  logic [1:0] n_id_2,
    input  logic [6:0] n,
    output logic       e
);

    localparam logic [SSS_LEN-1:0] X0 = gen_x0();
    localparam logic [SSS_LEN-1:0] X1 = gen_x1();

    logic [6:0] grp_off;
    logic [6:0] m0;
    logic [6:0] m1;
    logic [7:0] i0_sum;
    logic [7:0] i1_sum;
    logic [6:0] i0;
    logic [6:0] i1;

    // Shift derivation, modular index wrap and ROM lookup.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grp_off = 7'd0;
        m1      = n_id_1[6:0];
        // m1 = N_id_1 mod 112 always fits 7 bits, so mod-128 subtraction is exact.
        if (n_id_1 >= 9'd224) begin
            grp_off = 7'd30;
            m1      = n_id_1[6:0] - 7'd96;
        end else if (n_id_1 >= 9'd112) begin
            grp_off = 7'd15;
            m1      = n_id_1[6:0] - 7'd112;
        end
        // 5*N_id_2 as 4*N_id_2 + N_id_2.
        m0     = grp_off + {3'd0, n_id_2, 2'b00} + {5'd0, n_id_2};
        i0_sum = {1'b0, n} + {1'b0, m0};
        i1_sum = {1'b0, n} + {1'b0, m1};
        // Both sums stay below 254, so one conditional subtract is a full mod 127.
        i0     = (i0_sum >= 8'd127) ? 7'(i0_sum - 8'd127) : i0_sum[6:0];
        i1     = (i1_sum >= 8'd127) ? 7'(i1_sum - 8'd127) : i1_sum[6:0];
        e      = ~(X0[i0] ^ X1[i1]);
    end

endmodule

// File: rtl/sss_detector.sv
// NR SSS detector: collects 127 hard bits, scores all 336 N_id_1 candidates
// one bit-compare per cycle, and reports the best N_id_1 and N_id.
module sss_detector
    import sss_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [1:0] N_id_2_i,
    input  logic       N_id_2_valid_i,
    input  logic       s_axis_in_tdata,
    input  logic       s_axis_in_tvalid,
    output logic [8:0] m_axis_out_tdata,
    output logic       m_axis_out_tvalid,
    output logic [9:0] N_id_o
);

    state_t             state;
    state_t             state_next;
    logic [1:0]         n_id_2;
    logic [6:0]         cnt;
    logic [SSS_LEN-1:0] rx_buf;
    logic [8:0]         cand;
    logic [6:0]         n_idx;
    logic [7:0]         score;
    logic [7:0]         best_score;
    logic [8:0]         best_id;
    logic               exp_bit;
    logic               match;
    logic [7:0]         cand_score;
    logic               collect_last;
    logic               cand_last;
    logic               search_last;

    sss_seq_gen u_seq_gen (
        .n_id_1 (cand),
        .n_id_2 (n_id_2),
        .n      (n_idx),
        .e      (exp_bit)
    );

    // Compare of the current (candidate, n) pair and end-of-phase flags.
    always_comb begin
        match        = (rx_buf[n_idx] == exp_bit);
        cand_score   = score + {7'd0, match};
        collect_last = s_axis_in_tvalid && (cnt == 7'(SSS_LEN - 1));
        cand_last    = (n_idx == 7'(SSS_LEN - 1));
        search_last  = cand_last && (cand == 9'(N_ID_1_MAX));
    end

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_ni) state <= ST_IDLE;
        else           state <= state_next;
    end

    // Next-state logic; a new N_id_2 strobe restarts collection from any state.
    always_comb begin
        state_next = state;
        if (N_id_2_valid_i) begin
            state_next = ST_COLLECT;
        end else begin
            unique case (state)
                ST_IDLE:    state_next = ST_IDLE;
                ST_COLLECT: if (collect_last) state_next = ST_SEARCH;
                ST_SEARCH:  if (search_last)  state_next = ST_OUTPUT;
                ST_OUTPUT:  state_next = ST_COLLECT;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Bit buffer, candidate scoring and result registers.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            // NOTE: the rx buffer is plain flops, not RAM, so it can be cleared here.
            n_id_2            <= '0;
            cnt               <= '0;
            rx_buf            <= '0;
            cand              <= '0;
            n_idx             <= '0;
            score             <= '0;
            best_score        <= '0;
            best_id           <= '0;
            m_axis_out_tdata  <= '0;
            m_axis_out_tvalid <= 1'b0;
            N_id_o            <= '0;
        end else begin
            m_axis_out_tvalid <= 1'b0;
            if (N_id_2_valid_i) begin
                // Strobe wins: any bit presented in this cycle is dropped.
                n_id_2 <= N_id_2_i;
                cnt    <= '0;
            end else begin
                unique case (state)
                    ST_COLLECT: begin
                        if (s_axis_in_tvalid) begin
                            rx_buf[cnt] <= s_axis_in_tdata;
                            cnt         <= cnt + 7'd1;
                            if (collect_last) begin
                                cnt        <= '0;
                                cand       <= '0;
                                n_idx      <= '0;
                                score      <= '0;
                                best_score <= '0;
                                best_id    <= '0;
                            end
                        end
                    end
                    ST_SEARCH: begin
                        if (cand_last) begin
                            // Strictly greater keeps the lowest N_id_1 on a tie.
                            if (cand_score > best_score) begin
                                best_score <= cand_score;
                                best_id    <= cand;
                            end
                            score <= '0;
                            n_idx <= '0;
                            cand  <= cand + 9'd1;
                        end else begin
                            score <= cand_score;
                            n_idx <= n_idx + 7'd1;
                        end
                    end
                    ST_OUTPUT: begin
                        m_axis_out_tdata  <= best_id;
                        N_id_o            <= ({1'b0, best_id} << 1) + {1'b0, best_id} + {8'd0, n_id_2};
                        m_axis_out_tvalid <= 1'b1;
                        cnt               <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sss_detector.sv
// Directed bench for sss_detector: reference SSS sequences with hand-derived
// expected N_id_1 / N_id, exact latency, strobe abort and reset behaviour.
module tb_sss_detector;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [1:0] N_id_2_i;
    logic       N_id_2_valid_i;
    logic       s_axis_in_tdata;
    logic       s_axis_in_tvalid;
    logic [8:0] m_axis_out_tdata;
    logic       m_axis_out_tvalid;
    logic [9:0] N_id_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic x0 [127];
    logic x1 [127];

    sss_detector dut (
        .clk_i             (clk_i),
        .reset_ni          (reset_ni),
        .N_id_2_i          (N_id_2_i),
        .N_id_2_valid_i    (N_id_2_valid_i),
        .s_axis_in_tdata   (s_axis_in_tdata),
        .s_axis_in_tvalid  (s_axis_in_tvalid),
        .m_axis_out_tdata  (m_axis_out_tdata),
        .m_axis_out_tvalid (m_axis_out_tvalid),
        .N_id_o            (N_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic ref_bit(input int id1, input int id2, input int n);
        int m0;
        int m1;
        m0 = 15 * (id1 / 112) + 5 * id2;
        m1 = id1 % 112;
        return ~(x0[(n + m0) % 127] ^ x1[(n + m1) % 127]);
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk_i);
        s_axis_in_tdata  = b;
        s_axis_in_tvalid = 1'b1;
        @(posedge clk_i);
        #1;
        s_axis_in_tvalid = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk_i);
        s_axis_in_tvalid = 1'b0;
        s_axis_in_tdata  = ~s_axis_in_tdata;
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic [1:0] v, input logic with_bit);
        @(negedge clk_i);
        N_id_2_i         = v;
        N_id_2_valid_i   = 1'b1;
        s_axis_in_tvalid = with_bit;
        s_axis_in_tdata  = 1'b1;
        @(posedge clk_i);
        #1;
        N_id_2_valid_i   = 1'b0;
        s_axis_in_tvalid = 1'b0;
    endtask

    // Feeds the 127-bit reference; optional 20 flipped bits and tvalid gaps.
    task automatic feed_seq(input int id1, input int id2, input bit flip, input bit gaps);
        logic b;
        for (int n = 0; n < 127; n++) begin
            b = ref_bit(id1, id2, n);
            if (flip && (n % 6 == 3) && (n < 120)) b = ~b;
            if (gaps && (n % 5 == 2)) gap();
            send_bit(b);
        end
    endtask

    // Called right after the last bit is accepted; expects the result 42,673 cycles later.
    task automatic wait_result(input string tag, input int exp_id1, input int exp_nid);
        int lat;
        lat = 0;
        for (int i = 1; i <= 43000; i++) begin
            @(posedge clk_i);
            #1;
            if (m_axis_out_tvalid) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, lat, 42673);
        check({tag, " N_id_1"}, int'(m_axis_out_tdata), exp_id1);
        check({tag, " N_id"}, int'(N_id_o), exp_nid);
        @(posedge clk_i);
        #1;
        check({tag, " pulse width"}, int'(m_axis_out_tvalid), 0);
    endtask

    task automatic watch_no_valid(input string tag, input int ncyc);
        int hits;
        hits = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk_i);
            #1;
            if (m_axis_out_tvalid) hits++;
        end
        check(tag, hits, 0);
    endtask

    initial begin
        for (int i = 0; i < 127; i++) begin
            x0[i] = 1'b0;
            x1[i] = 1'b0;
        end
        x0[0] = 1'b1;
        x1[0] = 1'b1;
        for (int i = 0; i < 120; i++) begin
            x0[i+7] = x0[i+4] ^ x0[i];
            x1[i+7] = x1[i+1] ^ x1[i];
        end

        reset_ni         = 1'b0;
        N_id_2_i         = 2'd0;
        N_id_2_valid_i   = 1'b0;
        s_axis_in_tdata  = 1'b0;
        s_axis_in_tvalid = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset tdata", int'(m_axis_out_tdata), 0);
        check("reset N_id", int'(N_id_o), 0);
        check("reset tvalid", int'(m_axis_out_tvalid), 0);
        @(negedge clk_i);
        reset_ni = 1'b1;

        // A: 60 stray bits, then N_id_2=2 strobe carrying a bit that must be
        // dropped, then N_id_1=335 with 20 flips and gaps -> 335 / 1007.
        strobe(2'd0, 1'b0);
        for (int n = 0; n < 60; n++) send_bit(ref_bit(7, 0, n));
        strobe(2'd2, 1'b1);
        feed_seq(335, 2, 1'b1, 1'b1);
        wait_result("A", 335, 1007);

        // B: no new strobe, N_id_2 stays 2; N_id_1=112 -> N_id 338.
        feed_seq(112, 2, 1'b0, 1'b0);
        check("hold tdata", int'(m_axis_out_tdata), 335);
        check("hold N_id", int'(N_id_o), 1007);
        wait_result("B", 112, 338);

        // C: strobe abort during SEARCH, then reset during the restarted search.
        strobe(2'd1, 1'b0);
        feed_seq(69, 1, 1'b0, 1'b0);
        watch_no_valid("search quiet", 300);
        strobe(2'd0, 1'b1);
        feed_seq(0, 0, 1'b0, 1'b0);
        watch_no_valid("restart quiet", 300);
        @(negedge clk_i);
        reset_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("midsearch reset tdata", int'(m_axis_out_tdata), 0);
        check("midsearch reset N_id", int'(N_id_o), 0);
        check("midsearch reset tvalid", int'(m_axis_out_tvalid), 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        feed_seq(0, 0, 1'b0, 1'b0);
        watch_no_valid("idle ignores bits", 300);
        check("idle tdata", int'(m_axis_out_tdata), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
